// File: rtl/mem_arb_pkg.sv
// Shared encodings for the SDRAM burst-port arbiter: FSM states, grant sides
// and the counter widths used by the watchdog and the inter-grant gap.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_BUSY = 2'd1,
    S_RD_BUSY = 2'd2,
    S_GAP     = 2'd3
  } arb_state_e;

  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

  localparam int WD_BITS  = 12;
  localparam int GAP_BITS = 4;

endpackage

// File: rtl/mem_burst_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller burst port between the
// frame FIFO write sequencer and read sequencer. One whole burst is granted
// at a time; handshakes and data are routed only to the granted side.
module mem_burst_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_DATA_BITS  = 32,
  parameter int ADDR_BITS      = 23,
  parameter int BUSRT_BITS     = 10,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                     mem_clk,
  input  logic                     rst_n,
  // write requester
  input  logic                     wr_burst_req,
  input  logic [BUSRT_BITS-1:0]    wr_burst_len,
  input  logic [ADDR_BITS-1:0]     wr_burst_addr,
  input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
  output logic                     wr_burst_data_req,
  output logic                     wr_burst_finish,
  // read requester
  input  logic                     rd_burst_req,
  input  logic [BUSRT_BITS-1:0]    rd_burst_len,
  input  logic [ADDR_BITS-1:0]     rd_burst_addr,
  output logic [MEM_DATA_BITS-1:0] rd_burst_data,
  output logic                     rd_burst_data_valid,
  output logic                     rd_burst_finish,
  // controller write port
  output logic                     mem_wr_req,
  output logic [BUSRT_BITS-1:0]    mem_wr_len,
  output logic [ADDR_BITS-1:0]     mem_wr_addr,
  output logic [MEM_DATA_BITS-1:0] mem_wr_data,
  input  logic                     mem_wr_data_req,
  input  logic                     mem_wr_finish,
  // controller read port
  output logic                     mem_rd_req,
  output logic [BUSRT_BITS-1:0]    mem_rd_len,
  output logic [ADDR_BITS-1:0]     mem_rd_addr,
  input  logic [MEM_DATA_BITS-1:0] mem_rd_data,
  input  logic                     mem_rd_data_valid,
  input  logic                     mem_rd_finish,
  // status
  output logic                     timeout_err
);

  // Watchdog fires on the last cycle of a TIMEOUT_CYCLES-long grant.
  localparam logic [WD_BITS-1:0]  WD_LAST   = WD_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic                WD_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [GAP_BITS-1:0] GAP_LAST  = GAP_BITS'(GAP_CYCLES - 1);
  localparam arb_state_e          POST_BUSY = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  arb_state_e                state_q, state_d;
  logic                      last_grant_q, last_grant_d;
  logic [WD_BITS-1:0]        wd_q, wd_d;
  logic [GAP_BITS-1:0]       gap_q, gap_d;
  logic                      wr_fin_q, wr_fin_d;
  logic                      rd_fin_q, rd_fin_d;
  logic                      terr_q, terr_d;
  logic [BUSRT_BITS-1:0]     len_q, len_d;
  logic [ADDR_BITS-1:0]      addr_q, addr_d;

  logic wr_busy;
  logic rd_busy;
  logic wd_expired;

  assign wr_busy    = (state_q == S_WR_BUSY);
  assign rd_busy    = (state_q == S_RD_BUSY);
  assign wd_expired = WD_EN && (wd_q == WD_LAST);

  // Control state register: FSM, fairness pointer, counters, finish pulses, sticky error.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_RD;
      wd_q         <= '0;
      gap_q        <= '0;
      wr_fin_q     <= 1'b0;
      rd_fin_q     <= 1'b0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wd_q         <= wd_d;
      gap_q        <= gap_d;
      wr_fin_q     <= wr_fin_d;
      rd_fin_q     <= rd_fin_d;
      terr_q       <= terr_d;
    end
  end

  // Latched burst descriptor; outputs are gated by state so it needs no reset.
  always_ff @(posedge mem_clk) begin
    len_q  <= len_d;
    addr_q <= addr_d;
  end

  // Next-state logic: grant selection, burst completion, watchdog and gap timing.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wd_d         = wd_q;
    gap_d        = gap_q;
    wr_fin_d     = 1'b0;
    rd_fin_d     = 1'b0;
    terr_d       = terr_q;
    len_d        = len_q;
    addr_d       = addr_q;

    case (state_q)
      S_IDLE: begin
        wd_d = '0;
        // On a tie the side that did not have the last grant wins.
        if (wr_burst_req && (!rd_burst_req || last_grant_q == GRANT_RD)) begin
          state_d = S_WR_BUSY;
          len_d   = wr_burst_len;
          addr_d  = wr_burst_addr;
        end else if (rd_burst_req) begin
          state_d = S_RD_BUSY;
          len_d   = rd_burst_len;
          addr_d  = rd_burst_addr;
        end
      end

      S_WR_BUSY: begin
        wd_d = wd_q + 1'b1;
        // A real finish takes priority over a coincident watchdog expiry.
        if (mem_wr_finish || wd_expired) begin
          state_d      = POST_BUSY;
          gap_d        = '0;
          wr_fin_d     = 1'b1;
          last_grant_d = GRANT_WR;
          if (!mem_wr_finish) terr_d = 1'b1;
        end
      end

      S_RD_BUSY: begin
        wd_d = wd_q + 1'b1;
        if (mem_rd_finish || wd_expired) begin
          state_d      = POST_BUSY;
          gap_d        = '0;
          rd_fin_d     = 1'b1;
          last_grant_d = GRANT_RD;
          if (!mem_rd_finish) terr_d = 1'b1;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Controller side: request follows the busy state, descriptor from the latched copy.
  assign mem_wr_req  = wr_busy;
  assign mem_wr_len  = wr_busy ? len_q  : '0;
  assign mem_wr_addr = wr_busy ? addr_q : '0;
  assign mem_wr_data = wr_busy ? wr_burst_data : '0;
  assign mem_rd_req  = rd_busy;
  assign mem_rd_len  = rd_busy ? len_q  : '0;
  assign mem_rd_addr = rd_busy ? addr_q : '0;

  // Requester side: handshakes reach only the granted requester.
  assign wr_burst_data_req   = wr_busy & mem_wr_data_req;
  assign wr_burst_finish     = wr_fin_q;
  assign rd_burst_data       = rd_busy ? mem_rd_data : '0;
  assign rd_burst_data_valid = rd_busy & mem_rd_data_valid;
  assign rd_burst_finish     = rd_fin_q;
  assign timeout_err         = terr_q;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Directed bench for mem_burst_arbiter with a scoreboard of expected grants.
// dut runs against a behavioural controller; dut_to has a silent controller
// and a 16-cycle watchdog so its first grant must time out.
module tb_mem_burst_arbiter;

  localparam int DW = 32;
  localparam int AW = 23;
  localparam int LW = 10;

  typedef struct {
    logic          side;   // 0 = write, 1 = read
    logic [LW-1:0] len;
    logic [AW-1:0] addr;
  } exp_t;

  logic mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  logic          rst_n;
  logic          wr_burst_req;
  logic [LW-1:0] wr_burst_len;
  logic [AW-1:0] wr_burst_addr;
  logic [DW-1:0] wr_burst_data;
  logic          rd_burst_req;
  logic [LW-1:0] rd_burst_len;
  logic [AW-1:0] rd_burst_addr;
  logic          stray_rd_fin;

  // main DUT outputs
  logic          wr_burst_data_req, wr_burst_finish;
  logic [DW-1:0] rd_burst_data;
  logic          rd_burst_data_valid, rd_burst_finish;
  logic          mem_wr_req, mem_rd_req, timeout_err;
  logic [LW-1:0] mem_wr_len, mem_rd_len;
  logic [AW-1:0] mem_wr_addr, mem_rd_addr;
  logic [DW-1:0] mem_wr_data;

  // controller model
  logic          m_wr_data_req, m_wr_finish, m_rd_valid, m_rd_finish;
  logic [DW-1:0] m_rd_data;
  logic          wbusy, rbusy;
  int            wcnt, rcnt;

  // watchdog DUT outputs
  logic          t_wr_burst_data_req, t_wr_burst_finish;
  logic [DW-1:0] t_rd_burst_data;
  logic          t_rd_burst_data_valid, t_rd_burst_finish;
  logic          t_mem_wr_req, t_mem_rd_req, t_timeout_err;
  logic [LW-1:0] t_mem_wr_len, t_mem_rd_len;
  logic [AW-1:0] t_mem_wr_addr, t_mem_rd_addr;
  logic [DW-1:0] t_mem_wr_data;

  mem_burst_arbiter #(
    .MEM_DATA_BITS(DW), .ADDR_BITS(AW), .BUSRT_BITS(LW),
    .GAP_CYCLES(2), .TIMEOUT_CYCLES(4095)
  ) dut (
    .mem_clk(mem_clk), .rst_n(rst_n),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len),
    .wr_burst_addr(wr_burst_addr), .wr_burst_data(wr_burst_data),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_finish(wr_burst_finish),
    .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len),
    .rd_burst_addr(rd_burst_addr), .rd_burst_data(rd_burst_data),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_finish(rd_burst_finish),
    .mem_wr_req(mem_wr_req), .mem_wr_len(mem_wr_len), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_data_req(m_wr_data_req), .mem_wr_finish(m_wr_finish),
    .mem_rd_req(mem_rd_req), .mem_rd_len(mem_rd_len), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(m_rd_data), .mem_rd_data_valid(m_rd_valid),
    .mem_rd_finish(m_rd_finish | stray_rd_fin),
    .timeout_err(timeout_err)
  );

  mem_burst_arbiter #(
    .MEM_DATA_BITS(DW), .ADDR_BITS(AW), .BUSRT_BITS(LW),
    .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)
  ) dut_to (
    .mem_clk(mem_clk), .rst_n(rst_n),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len),
    .wr_burst_addr(wr_burst_addr), .wr_burst_data(wr_burst_data),
    .wr_burst_data_req(t_wr_burst_data_req), .wr_burst_finish(t_wr_burst_finish),
    .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len),
    .rd_burst_addr(rd_burst_addr), .rd_burst_data(t_rd_burst_data),
    .rd_burst_data_valid(t_rd_burst_data_valid), .rd_burst_finish(t_rd_burst_finish),
    .mem_wr_req(t_mem_wr_req), .mem_wr_len(t_mem_wr_len), .mem_wr_addr(t_mem_wr_addr),
    .mem_wr_data(t_mem_wr_data), .mem_wr_data_req(1'b0), .mem_wr_finish(1'b0),
    .mem_rd_req(t_mem_rd_req), .mem_rd_len(t_mem_rd_len), .mem_rd_addr(t_mem_rd_addr),
    .mem_rd_data(32'd0), .mem_rd_data_valid(1'b0), .mem_rd_finish(1'b0),
    .timeout_err(t_timeout_err)
  );

  // Behavioural controller: after seeing a request, len data beats then a finish pulse.
  always @(posedge mem_clk) begin
    if (!rst_n) begin
      m_wr_data_req <= 1'b0; m_wr_finish <= 1'b0; wbusy <= 1'b0; wcnt <= 0;
      m_rd_valid <= 1'b0; m_rd_finish <= 1'b0; rbusy <= 1'b0; rcnt <= 0;
      m_rd_data <= 32'h1000_0000;
    end else begin
      m_wr_data_req <= 1'b0; m_wr_finish <= 1'b0;
      if (!mem_wr_req) wbusy <= 1'b0;
      else if (!wbusy && !m_wr_finish) begin wbusy <= 1'b1; wcnt <= int'(mem_wr_len); end
      else if (wbusy) begin
        if (wcnt > 0) begin m_wr_data_req <= 1'b1; wcnt <= wcnt - 1; end
        else begin m_wr_finish <= 1'b1; wbusy <= 1'b0; end
      end
      m_rd_valid <= 1'b0; m_rd_finish <= 1'b0;
      if (!mem_rd_req) rbusy <= 1'b0;
      else if (!rbusy && !m_rd_finish) begin rbusy <= 1'b1; rcnt <= int'(mem_rd_len); end
      else if (rbusy) begin
        if (rcnt > 0) begin
          m_rd_valid <= 1'b1; m_rd_data <= m_rd_data + 32'd1; rcnt <= rcnt - 1;
        end else begin m_rd_finish <= 1'b1; rbusy <= 1'b0; end
      end
    end
  end

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic prev_wr = 1'b0, prev_rd = 1'b0, t_prev = 1'b0;
  logic gap_chk = 1'b0, fell = 1'b0, t_done = 1'b0;
  int   idle = 0, wdr = 0, rdv = 0, fin_total = 0, t_hi = 0;
  int   cur_wr_len = 0, cur_rd_len = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: sample at the falling edge and run every per-cycle check.
  task automatic tick();
    logic wr_rise, rd_rise;
    exp_t e;
    @(negedge mem_clk);
    if (rst_n) begin
      check("one_req", 32'(mem_wr_req & mem_rd_req), 32'd0);
      wr_rise = mem_wr_req && !prev_wr;
      rd_rise = mem_rd_req && !prev_rd;
      if (wr_rise || rd_rise) begin
        if (sb.size() == 0) begin
          check("unexpected_grant", {30'd0, mem_rd_req, mem_wr_req}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("grant_side", {30'd0, mem_rd_req, mem_wr_req}, e.side ? 32'd2 : 32'd1);
          check("grant_len", mem_wr_req ? 32'(mem_wr_len) : 32'(mem_rd_len), 32'(e.len));
          check("grant_addr", mem_wr_req ? 32'(mem_wr_addr) : 32'(mem_rd_addr), 32'(e.addr));
          if (mem_wr_req) cur_wr_len = int'(e.len);
          else            cur_rd_len = int'(e.len);
          if (gap_chk && fell) check("gap_idle", 32'(idle), 32'd3);
        end
        fell = 1'b0;
      end else begin
        if (mem_wr_req) check("wr_len_hold", 32'(mem_wr_len), 32'(cur_wr_len));
        if (mem_rd_req) check("rd_len_hold", 32'(mem_rd_len), 32'(cur_rd_len));
      end
      if ((prev_wr && !mem_wr_req) || (prev_rd && !mem_rd_req)) begin
        fell = 1'b1; idle = 1;
      end else if (!mem_wr_req && !mem_rd_req) begin
        idle++;
      end
      if (wr_burst_data_req) begin
        wdr++;
        check("wr_data_pass", mem_wr_data, wr_burst_data);
      end
      if (rd_burst_data_valid) begin
        rdv++;
        check("rd_data_pass", rd_burst_data, m_rd_data);
      end
      if (wr_burst_finish) begin
        fin_total++;
        check("wr_beats", 32'(wdr), 32'(cur_wr_len));
        check("wr_req_drop", 32'(mem_wr_req), 32'd0);
        wdr = 0;
      end
      if (rd_burst_finish) begin
        fin_total++;
        check("rd_beats", 32'(rdv), 32'(cur_rd_len));
        check("rd_req_drop", 32'(mem_rd_req), 32'd0);
        rdv = 0;
      end
      // watchdog instance: first grant must last exactly 16 cycles
      if (t_mem_wr_req && !t_prev) begin
        t_hi = 0;
        if (!t_done) check("to_err_before", 32'(t_timeout_err), 32'd0);
      end
      if (t_mem_wr_req) t_hi++;
      if (!t_mem_wr_req && t_prev && !t_done) begin
        check("to_req_cycles", 32'(t_hi), 32'd16);
        check("to_finish_pulse", 32'(t_wr_burst_finish), 32'd1);
        check("to_err_set", 32'(t_timeout_err), 32'd1);
        t_done = 1'b1;
      end
    end
    prev_wr = mem_wr_req;
    prev_rd = mem_rd_req;
    t_prev  = t_mem_wr_req;
    wr_burst_data = $urandom;
  endtask

  task automatic wait_fins(input int n, input int budget, input string tag);
    int start;
    int k;
    start = fin_total;
    k = 0;
    while ((fin_total - start) < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(fin_total - start), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n = 1'b0;
    wr_burst_req = 1'b0; wr_burst_len = '0; wr_burst_addr = '0; wr_burst_data = '0;
    rd_burst_req = 1'b0; rd_burst_len = '0; rd_burst_addr = '0; stray_rd_fin = 1'b0;
    repeat (3) tick();
    // reset state
    check("rst_mem_wr_req", 32'(mem_wr_req), 32'd0);
    check("rst_mem_rd_req", 32'(mem_rd_req), 32'd0);
    check("rst_wr_finish", 32'(wr_burst_finish), 32'd0);
    check("rst_rd_finish", 32'(rd_burst_finish), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_mem_wr_len", 32'(mem_wr_len), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // single write burst, 128 words at 0x100 (watchdog instance times out meanwhile)
    wr_burst_len = 10'd128; wr_burst_addr = 23'h100; wr_burst_req = 1'b1;
    sb.push_back('{1'b0, 10'd128, 23'h100});
    tick();
    check("wr_grant_latency", 32'(mem_wr_req), 32'd1);
    repeat (20) tick();
    stray_rd_fin = 1'b1;
    tick();
    stray_rd_fin = 1'b0;
    tick();
    check("stray_rd_fin_ignored", 32'(rd_burst_finish), 32'd0);
    check("stray_wr_still_busy", 32'(mem_wr_req), 32'd1);
    wait_fins(1, 300, "wr_burst_done");
    wr_burst_req = 1'b0;
    check("wr_no_timeout", 32'(timeout_err), 32'd0);
    check("watchdog_seen", 32'(t_done), 32'd1);
    repeat (5) tick();

    // read burst with requester length changed mid-burst
    rd_burst_len = 10'd100; rd_burst_addr = 23'h2000; rd_burst_req = 1'b1;
    sb.push_back('{1'b1, 10'd100, 23'h2000});
    repeat (10) tick();
    rd_burst_len = 10'd50; rd_burst_addr = 23'h3000;
    tick();
    check("rd_len_latched", 32'(mem_rd_len), 32'd100);
    wait_fins(1, 300, "rd_burst_done");
    rd_burst_req = 1'b0;
    repeat (5) tick();

    // both requesters held: grants alternate with a 3-cycle idle gap
    wr_burst_len = 10'd8; wr_burst_addr = 23'h300;
    rd_burst_len = 10'd6; rd_burst_addr = 23'h400;
    sb.push_back('{1'b0, 10'd8, 23'h300});
    sb.push_back('{1'b1, 10'd6, 23'h400});
    sb.push_back('{1'b0, 10'd8, 23'h300});
    sb.push_back('{1'b1, 10'd6, 23'h400});
    gap_chk = 1'b1; fell = 1'b0;
    wr_burst_req = 1'b1; rd_burst_req = 1'b1;
    wait_fins(4, 400, "alternate_done");
    wr_burst_req = 1'b0; rd_burst_req = 1'b0;
    repeat (8) tick();
    gap_chk = 1'b0;
    check("alt_sb_drained", 32'(sb.size()), 32'd0);

    // reset in the middle of a write burst
    wr_burst_len = 10'd20; wr_burst_addr = 23'h500; wr_burst_req = 1'b1;
    sb.push_back('{1'b0, 10'd20, 23'h500});
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_mem_wr_req", 32'(mem_wr_req), 32'd0);
    check("midrst_wr_data_req", 32'(wr_burst_data_req), 32'd0);
    check("midrst_mem_wr_addr", 32'(mem_wr_addr), 32'd0);
    check("midrst_to_err_clear", 32'(t_timeout_err), 32'd0);
    wr_burst_req = 1'b0;
    sb.delete(); wdr = 0; rdv = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    wr_burst_len = 10'd4; wr_burst_addr = 23'h600;
    rd_burst_len = 10'd3; rd_burst_addr = 23'h700;
    sb.push_back('{1'b0, 10'd4, 23'h600});
    sb.push_back('{1'b1, 10'd3, 23'h700});
    wr_burst_req = 1'b1; rd_burst_req = 1'b1;
    wait_fins(2, 200, "post_reset_done");
    wr_burst_req = 1'b0; rd_burst_req = 1'b0;
    repeat (8) tick();
    check("final_sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
